mem_bist_ctrl: RTL

Built-in self-test controller and access arbiter for the `reg_mem` register memory. It owns the memory's single address/data/write-enable port. When idle it passes host accesses straight through. On `start` it takes the port and runs a four-phase write/read-verify sweep over every address, with a true pattern pass and an inverted pattern pass. It reports pass/fail, a saturating error count and the first failing address.

---
 rtl/mem_bist_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: march-style BIST controller and host/controller arbiter for reg_mem
module mem_bist_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5,
  parameter int ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [ADDR_BITS-1:0]  host_addr,
  input  logic [DATA_WIDTH-1:0] host_din,
  input  logic                  host_wen,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic                  first_err_valid,
  output logic [ADDR_BITS-1:0]  first_err_addr,
  output logic                  first_err_phase
);
  typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;
  state_t state, next_phase;
  logic [ADDR_BITS-1:0] cnt;
  logic [DATA_WIDTH-1:0] seed_q, pat, exp_d;
  logic ctl, inv, rd, miss, wrap;
  assign pat = DATA_WIDTH'(cnt) + seed_q;
  assign inv = state == W1 || state == R1;
  assign exp_d = inv ? ~pat : pat;
  assign rd = state == R0 || state == R1;
  assign miss = rd && mem_dout != exp_d;
  assign wrap = cnt == '1;
  // reset takes the port away from the controller at once so no write lands on the aborting edge
  assign ctl = busy && rst_n;
  assign mem_addr = ctl ? cnt : host_addr;
  assign mem_din = ctl ? exp_d : host_din;
  assign mem_wen = ctl ? (state == W0 || state == W1) : host_wen;
  assign next_phase = state == W0 ? R0 : state == R0 ? W1 : state == W1 ? R1 : DONE;
  // sequencer: start acceptance, phase sweep, error capture and final verdict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      seed_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_err_valid <= 1'b0;
      first_err_addr <= '0;
      first_err_phase <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= W0;
            seed_q <= seed;
            cnt <= '0;
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
            err_count <= '0;
            first_err_valid <= 1'b0;
            first_err_addr <= '0;
            first_err_phase <= 1'b0;
          end
        end
        default: begin
          cnt <= cnt + 1'b1;
          if (miss) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_addr <= cnt;
              first_err_phase <= inv;
            end
          end
          if (wrap) begin
            state <= next_phase;
            if (state == R1) begin
              busy <= 1'b0;
              done <= 1'b1;
              pass <= !(first_err_valid || miss);
            end
          end
        end
      endcase
    end
  end
endmodule
